hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage MIPS core. Detects load-use hazards

---
 rtl/hazard_ctrl_pkg.sv | 24 ++
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and the load-use compare for the pipeline hazard controller.
// Pure definitions: no state, no timing.
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MDU = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $zero is never a real dependency, so a load into r0 cannot cause a hazard.
  function automatic logic load_use(
    input logic       memread,
    input logic [4:0] idex_rt,
    input logic [4:0] ifid_rs,
    input logic [4:0] ifid_rt,
    input logic       use_rt
  );
    return memread && (idex_rt != REG_ZERO) &&
           ((idex_rt == ifid_rs) || (use_rt && (idex_rt == ifid_rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard inputs from the pipeline registers and the buffer/PC controls driven back.
// Combinational bundle; no handshake, every signal is sampled every cycle.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             in_idex_memread;
  logic [4:0]       in_idex_rt;
  logic [4:0]       in_ifid_rs;
  logic [4:0]       in_ifid_rt;
  logic             in_ifid_use_rt;
  logic             in_branch_taken;
  logic             in_mdu_start;

  logic             ou_pc_we;
  logic             ou_ifid_we;
  logic             ou_ifid_flush;
  logic             ou_idex_we;
  logic             ou_idex_bubble;
  logic             ou_exmem_bubble;
  logic [CNT_W-1:0] ou_stall_cnt;

  modport master (
    output in_idex_memread, in_idex_rt, in_ifid_rs, in_ifid_rt,
           in_ifid_use_rt, in_branch_taken, in_mdu_start,
    input  ou_pc_we, ou_ifid_we, ou_ifid_flush, ou_idex_we,
           ou_idex_bubble, ou_exmem_bubble, ou_stall_cnt
  );

  modport slave (
    input  in_idex_memread, in_idex_rt, in_ifid_rs, in_ifid_rt,
           in_ifid_use_rt, in_branch_taken, in_mdu_start,
    output ou_pc_we, ou_ifid_we, ou_ifid_flush, ou_idex_we,
           ou_idex_bubble, ou_exmem_bubble, ou_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stall, taken-branch flush, mult/div front-end hold.
// Controls are zero-cycle combinational from state+inputs; stall counter is registered.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  localparam int            CW       = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [CW-1:0] MDU_LOAD = CW'((MDU_LAT >= 2) ? (MDU_LAT - 2) : 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;
  logic             w_lu;

  logic w_pc_we, w_ifid_we, w_ifid_flush, w_idex_we, w_idex_bubble, w_exmem_bubble;

  assign w_lu = load_use(bus.in_idex_memread, bus.in_idex_rt, bus.in_ifid_rs,
                         bus.in_ifid_rt, bus.in_ifid_use_rt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Priority in RUN: branch > mdu_start > load-use (a start and a load share the ID/EX slot).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.in_branch_taken) begin
          w_stall = 1'b0;
        end else if (bus.in_mdu_start) begin
          if (MDU_LAT > 1) begin
            w_state_nxt = ST_MDU;
            w_cnt_nxt   = MDU_LOAD;
          end
        end else if (w_lu) begin
          w_stall = 1'b1;
        end
      end
      ST_MDU: begin
        w_stall = 1'b1;
        if (r_cnt == '0)
          w_state_nxt = ST_RUN;
        else
          w_cnt_nxt = r_cnt - CW'(1);
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_pc_we        = 1'b1;
    w_ifid_we      = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_we      = 1'b1;
    w_idex_bubble  = 1'b0;
    w_exmem_bubble = 1'b0;
    if (!rst_n) begin
      w_pc_we        = 1'b0;
      w_ifid_we      = 1'b0;
      w_ifid_flush   = 1'b1;
      w_idex_bubble  = 1'b1;
      w_exmem_bubble = 1'b1;
    end else if (r_state == ST_MDU) begin
      w_pc_we        = 1'b0;
      w_ifid_we      = 1'b0;
      w_idex_we      = 1'b0;
      w_exmem_bubble = 1'b1;
    end else if (bus.in_branch_taken) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (!bus.in_mdu_start && w_lu) begin
      w_pc_we       = 1'b0;
      w_ifid_we     = 1'b0;
      w_idex_bubble = 1'b1;
    end
  end

  assign bus.ou_pc_we        = w_pc_we;
  assign bus.ou_ifid_we      = w_ifid_we;
  assign bus.ou_ifid_flush   = w_ifid_flush;
  assign bus.ou_idex_we      = w_idex_we;
  assign bus.ou_idex_bubble  = w_idex_bubble;
  assign bus.ou_exmem_bubble = w_exmem_bubble;
  assign bus.ou_stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a cycle model.
// Two instances share stimulus; the CNT_W=2 one exposes counter saturation.
module tb_hazard_ctrl;

  localparam int MDU_LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) bus_a ();
  hazard_ctrl_if #(.CNT_W(2))  bus_b ();

  hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(16)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(2))  u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble}
  wire [5:0] ctl_a = {bus_a.ou_pc_we, bus_a.ou_ifid_we, bus_a.ou_ifid_flush,
                      bus_a.ou_idex_we, bus_a.ou_idex_bubble, bus_a.ou_exmem_bubble};
  wire [5:0] ctl_b = {bus_b.ou_pc_we, bus_b.ou_ifid_we, bus_b.ou_ifid_flush,
                      bus_b.ou_idex_we, bus_b.ou_idex_bubble, bus_b.ou_exmem_bubble};

  int checks = 0;
  int errors = 0;

  // Reference model: remaining hold cycles and total stall cycles.
  int        m_busy = 0;
  int        m_cnt  = 0;
  logic [5:0] m_ctl;
  logic       s_rst, s_mr, s_urt, s_br, s_mdu;
  logic [4:0] s_drt, s_rs, s_rt;

  function automatic logic m_lu();
    return s_mr && (s_drt != 0) && ((s_drt == s_rs) || (s_urt && (s_drt == s_rt)));
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic apply(input logic rst, input logic mr, input logic [4:0] drt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic br, input logic mdu);
    s_rst = rst; s_mr = mr; s_drt = drt; s_rs = rs; s_rt = rt; s_urt = urt; s_br = br; s_mdu = mdu;
    rst_n = rst;
    bus_a.in_idex_memread = mr;  bus_b.in_idex_memread = mr;
    bus_a.in_idex_rt      = drt; bus_b.in_idex_rt      = drt;
    bus_a.in_ifid_rs      = rs;  bus_b.in_ifid_rs      = rs;
    bus_a.in_ifid_rt      = rt;  bus_b.in_ifid_rt      = rt;
    bus_a.in_ifid_use_rt  = urt; bus_b.in_ifid_use_rt  = urt;
    bus_a.in_branch_taken = br;  bus_b.in_branch_taken = br;
    bus_a.in_mdu_start    = mdu; bus_b.in_mdu_start    = mdu;
    #2;
    if (!rst)            m_ctl = 6'b001111;
    else if (m_busy > 0) m_ctl = 6'b000001;
    else if (br)         m_ctl = 6'b111110;
    else if (mdu)        m_ctl = 6'b110100;
    else if (m_lu())     m_ctl = 6'b000110;
    else                 m_ctl = 6'b110100;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!s_rst) begin
      m_busy = 0;
      m_cnt  = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      m_cnt++;
    end else if (s_br) begin
      m_busy = 0;
    end else if (s_mdu) begin
      m_busy = MDU_LAT - 1;
    end else if (m_lu()) begin
      m_cnt++;
    end
    #1;
  endtask

  task automatic idle();
    apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    apply(1'b0, 1'b1, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1);
    checks++;
    if (ctl_a !== 6'b001111) begin
      errors++; $display("FAIL reset_ctl got %b want %b", ctl_a, 6'b001111);
    end
    tick();
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checks++;
    if (bus_a.ou_stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", bus_a.ou_stall_cnt);
    end
    checks++;
    if (ctl_a !== 6'b110100) begin
      errors++; $display("FAIL reset_release_ctl got %b want %b", ctl_a, 6'b110100);
    end
    tick();
  endtask

  task automatic test_load_use();
    apply(1'b1, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl_a !== 6'b000110) begin
      errors++; $display("FAIL lu_ctl got %b want %b", ctl_a, 6'b000110);
    end
    tick();
    checks++;
    if (bus_a.ou_stall_cnt !== 16'd1) begin
      errors++; $display("FAIL lu_cnt got %0d want 1", bus_a.ou_stall_cnt);
    end
    apply(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctl_a !== 6'b110100) begin
      errors++; $display("FAIL lu_r0_ctl got %b want %b", ctl_a, 6'b110100);
    end
    tick();
    checks++;
    if (bus_a.ou_stall_cnt !== 16'd1) begin
      errors++; $display("FAIL lu_r0_cnt got %0d want 1", bus_a.ou_stall_cnt);
    end
  endtask

  task automatic test_use_rt();
    apply(1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl_a !== m_ctl) begin
      errors++; $display("FAIL use_rt0_ctl got %b want %b", ctl_a, m_ctl);
    end
    tick();
    apply(1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctl_a !== m_ctl) begin
      errors++; $display("FAIL use_rt1_ctl got %b want %b", ctl_a, m_ctl);
    end
    tick();
    checks++;
    if (bus_a.ou_stall_cnt !== 16'(m_cnt)) begin
      errors++; $display("FAIL use_rt_cnt got %0d want %0d", bus_a.ou_stall_cnt, m_cnt);
    end
  endtask

  task automatic test_branch();
    int c0;
    c0 = m_cnt;
    apply(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    checks++;
    if (ctl_a !== 6'b111110) begin
      errors++; $display("FAIL br_lu_ctl got %b want %b", ctl_a, 6'b111110);
    end
    tick();
    checks++;
    if (bus_a.ou_stall_cnt !== 16'(c0)) begin
      errors++; $display("FAIL br_cnt got %0d want %0d", bus_a.ou_stall_cnt, c0);
    end
    // branch + mdu_start: branch wins, no hold follows
    apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    checks++;
    if (ctl_a !== 6'b110100) begin
      errors++; $display("FAIL br_mdu_drop got %b want %b", ctl_a, 6'b110100);
    end
    tick();
  endtask

  task automatic test_mdu();
    int c0, held;
    c0 = m_cnt; held = 0;
    apply(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ctl_a !== m_ctl) begin
      errors++; $display("FAIL mdu_start_ctl got %b want %b", ctl_a, m_ctl);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), (i < 3), 1'b0);
      checks++;
      if (ctl_a !== m_ctl) begin
        errors++; $display("FAIL mdu_busy_ctl[%0d] got %b want %b", i, ctl_a, m_ctl);
      end
      if (ctl_a === 6'b000001) held++;
      tick();
      if (i == 2) begin
        checks++;
        if (bus_a.ou_stall_cnt !== 16'(c0 + 3)) begin
          errors++; $display("FAIL mdu_cnt got %0d want %0d", bus_a.ou_stall_cnt, c0 + 3);
        end
      end
    end
    checks++;
    if (held !== 3) begin
      errors++; $display("FAIL mdu_hold_len got %0d want 3", held);
    end
  endtask

  task automatic test_mdu_reset();
    apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl_a !== 6'b001111) begin
      errors++; $display("FAIL mdu_rst_ctl got %b want %b", ctl_a, 6'b001111);
    end
    tick();
    idle();
    checks++;
    if (ctl_a !== 6'b110100) begin
      errors++; $display("FAIL mdu_rst_run got %b want %b", ctl_a, 6'b110100);
    end
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (bus_b.ou_stall_cnt !== 2'(sat3(m_cnt))) begin
        errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, bus_b.ou_stall_cnt, sat3(m_cnt));
      end
    end
    checks++;
    if (bus_b.ou_stall_cnt !== 2'd3) begin
      errors++; $display("FAIL sat_final got %0d want 3", bus_b.ou_stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 39) != 0), 1'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0));
      checks++;
      if (ctl_a !== m_ctl || ctl_b !== m_ctl) begin
        errors++; $display("FAIL rand_ctl[%0d] got %b/%b want %b", i, ctl_a, ctl_b, m_ctl);
      end
      tick();
      checks++;
      if (bus_a.ou_stall_cnt !== 16'(m_cnt) || bus_b.ou_stall_cnt !== 2'(sat3(m_cnt))) begin
        errors++; $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", i,
                           bus_a.ou_stall_cnt, bus_b.ou_stall_cnt, m_cnt, sat3(m_cnt));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    test_reset();
    test_load_use();
    test_use_rt();
    test_branch();
    test_mdu();
    test_mdu_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
